// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_rom_loader
// Brief    : Zero-latency instruction ROM for the core fetch port, filled from
//            a big-endian host byte stream; holds the core in reset until loaded.
// Revision : 1.0
// ============================================================================
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_byte_i,
    output logic                  load_ready_o,
    input  logic                  load_done_i,
    output logic                  cpu_rst_o,
    output logic [DEPTH_LOG2:0]   load_count_o,
    output logic                  err_o
);

    localparam int                c_WORDS = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = c_WORDS[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_LOG2:0]   r_wptr;
    logic [1:0]            r_bcnt;
    logic [23:0]           r_asm;
    logic                  r_err;
    logic [31:0]           r_mem [c_WORDS];

    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_take;
    logic                  w_drop;
    logic                  w_word_done;
    logic [1:0]            w_bcnt_nxt;
    logic [23:0]           w_asm_nxt;
    logic                  w_finish;
    logic                  w_pad;
    logic [31:0]           w_pad_word;
    logic                  w_we;
    logic [31:0]           w_wdata;
    logic                  w_in_range;
    logic                  w_unused_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        cpu_rst_o    = 1'b1;
        load_ready_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start_i) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready_o = 1'b1;
                if (load_done_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_rst_o = 1'b0;
                if (load_start_i) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_start_ok  = load_start_i && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_accept    = load_valid_i && (r_state == ST_LOAD);
    assign w_full      = (r_wptr == c_FULL);
    assign w_take      = w_accept && !w_full;
    assign w_drop      = w_accept && w_full;
    assign w_word_done = w_take && (r_bcnt == 2'd3);
    assign w_bcnt_nxt  = w_take ? (r_bcnt + 2'd1) : r_bcnt;
    assign w_asm_nxt   = w_take ? {r_asm[15:0], load_byte_i} : r_asm;

    // A byte arriving with done is folded in first, then any remainder is padded.
    assign w_finish    = load_done_i && (r_state == ST_LOAD);
    assign w_pad       = w_finish && (w_bcnt_nxt != 2'd0);

    always_comb begin
        w_pad_word = 32'h0;
        case (w_bcnt_nxt)
            2'd1:    w_pad_word = {w_asm_nxt[7:0], 24'h0};
            2'd2:    w_pad_word = {w_asm_nxt[15:0], 16'h0};
            2'd3:    w_pad_word = {w_asm_nxt, 8'h0};
            default: w_pad_word = 32'h0;
        endcase
    end

    assign w_we    = w_word_done || (w_pad && !w_full);
    assign w_wdata = w_word_done ? {r_asm, load_byte_i} : w_pad_word;

    // The write pointer doubles as the word count; a padded word bumps it too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_bcnt <= 2'd0;
            r_asm  <= 24'h0;
            r_err  <= 1'b0;
        end else if (w_start_ok) begin
            r_wptr <= '0;
            r_bcnt <= 2'd0;
            r_asm  <= 24'h0;
            r_err  <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_bcnt <= w_finish ? 2'd0 : w_bcnt_nxt;
            r_asm  <= w_asm_nxt;
            if (w_word_done || w_pad) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_drop || w_pad) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_wdata;
        end
    end

    assign w_in_range    = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
    assign w_unused_addr = ^rom_addr_i[1:0];
    assign rom_data_o    = (rom_ce_i && (r_state == ST_RUN) && w_in_range)
                         ? r_mem[rom_addr_i[DEPTH_LOG2+1:2]] : 32'h0;

    assign load_count_o = r_wptr;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_rom_loader
// Brief    : Randomized bench for inst_rom_loader against a byte-queue model.
// Revision : 1.0
// ============================================================================
module tb_inst_rom_loader;

    localparam int D = 2;
    localparam int W = 1 << D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce = 1'b0;
    logic [31:0] rom_addr = 32'h0;
    logic [31:0] rom_data;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = 8'h0;
    logic        load_ready;
    logic        load_done = 1'b0;
    logic        cpu_rst;
    logic [D:0]  load_count;
    logic        err;

    int total = 0;
    int bad   = 0;

    inst_rom_loader #(.DEPTH_LOG2(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_i     (rom_ce),
        .rom_addr_i   (rom_addr),
        .rom_data_o   (rom_data),
        .load_start_i (load_start),
        .load_valid_i (load_valid),
        .load_byte_i  (load_byte),
        .load_ready_o (load_ready),
        .load_done_i  (load_done),
        .cpu_rst_o    (cpu_rst),
        .load_count_o (load_count),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Model: "loading"/"running" flags, a queue of pending bytes, a word count.
    bit          m_load = 1'b0;
    bit          m_run  = 1'b0;
    int          m_count = 0;
    bit          m_err = 1'b0;
    logic [7:0]  m_q [$];
    logic [31:0] m_mem [W];
    bit          m_known [W];
    logic [31:0] m_pad;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_load = 1'b0; m_run = 1'b0; m_count = 0; m_err = 1'b0;
            m_q.delete();
        end else if (m_load) begin
            if (load_valid) begin
                if (m_count >= W) begin
                    m_err = 1'b1;
                end else begin
                    m_q.push_back(load_byte);
                    if (m_q.size() == 4) begin
                        m_mem[m_count]   = {m_q[0], m_q[1], m_q[2], m_q[3]};
                        m_known[m_count] = 1'b1;
                        m_count++;
                        m_q.delete();
                    end
                end
            end
            if (load_done) begin
                if (m_q.size() != 0) begin
                    m_pad = 32'h0;
                    for (int i = 0; i < m_q.size(); i++) m_pad[31-8*i -: 8] = m_q[i];
                    if (m_count < W) begin
                        m_mem[m_count]   = m_pad;
                        m_known[m_count] = 1'b1;
                    end
                    m_count++;
                    m_err = 1'b1;
                    m_q.delete();
                end
                m_load = 1'b0;
                m_run  = 1'b1;
            end
        end else if (load_start) begin
            m_load = 1'b1; m_run = 1'b0; m_count = 0; m_err = 1'b0;
            m_q.delete();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cpu_rst", 32'(cpu_rst), 32'(!m_run));
        chk("load_ready", 32'(load_ready), 32'(m_load));
        chk("load_count", 32'(load_count), 32'(m_count));
        chk("err", 32'(err), 32'(m_err));
        if (m_run && rom_ce && ((rom_addr >> (D + 2)) == 32'h0)) begin
            if (m_known[rom_addr[D+1:2]]) chk("rom_data", rom_data, m_mem[rom_addr[D+1:2]]);
        end else begin
            chk("rom_nop", rom_data, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit done);
        load_valid = 1'b1;
        load_byte  = b;
        load_done  = done;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        load_byte  = 8'($urandom);
        if ($urandom_range(0, 2) == 0) tick();
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rom_ce   = 1'b1;
        rom_addr = addr;
        @(negedge clk);
        chk(name, rom_data, exp);
        tick();
        rom_ce = 1'b0;
    endtask

    logic [7:0] ov [16];
    int         n;

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        tick();
        fetch(32'h0, 32'h0, "idle_fetch");

        // Two full words.
        pulse_start();
        send(8'h34, 0); send(8'h01, 0); send(8'h11, 0); send(8'h00, 0);
        send(8'h34, 0); send(8'h02, 0); send(8'h00, 0); send(8'h20, 0);
        chk("cpu_rst_before_done", 32'(cpu_rst), 32'd1);
        finish_load();
        chk("cpu_rst_after_done", 32'(cpu_rst), 32'd0);
        chk("count_two", 32'(load_count), 32'd2);
        chk("err_clean", 32'(err), 32'd0);
        fetch(32'h0, 32'h34011100, "fetch_0");
        fetch(32'h4, 32'h34020020, "fetch_4");
        fetch(32'h6, 32'h34020020, "fetch_6");

        // Partial word, done with the second byte.
        pulse_start();
        send(8'h3C, 0); send(8'h01, 1);
        chk("count_partial", 32'(load_count), 32'd1);
        chk("err_partial", 32'(err), 32'd1);
        fetch(32'h0, 32'h3C010000, "fetch_partial");
        fetch(32'h4, 32'h34020020, "fetch_retained");

        // Overflow: 20 bytes into a four-word memory.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < 16) ov[i] = b;
            send(b, 0);
        end
        chk("ready_drain", 32'(load_ready), 32'd1);
        finish_load();
        chk("count_ovf", 32'(load_count), 32'd4);
        chk("err_ovf", 32'(err), 32'd1);
        for (int k = 0; k < 4; k++)
            fetch(32'(4 * k), {ov[4*k], ov[4*k+1], ov[4*k+2], ov[4*k+3]}, "fetch_ovf_word");
        fetch(32'h10, 32'h0, "fetch_out_of_range");

        // Reload from RUN.
        pulse_start();
        chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload_err_clear", 32'(err), 32'd0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        finish_load();
        fetch(32'h0, 32'hAABBCCDD, "fetch_reload");
        fetch(32'h4, {ov[4], ov[5], ov[6], ov[7]}, "fetch_reload_keep");

        // Async reset mid-word.
        pulse_start();
        send(8'h55, 0); send(8'h66, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_ready", 32'(load_ready), 32'd0);
        chk("async_cpu_rst", 32'(cpu_rst), 32'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        pulse_start();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        finish_load();
        chk("count_after_rst", 32'(load_count), 32'd1);
        fetch(32'h0, 32'h11223344, "fetch_after_rst");

        // Randomized loads with ignored inputs sprinkled in.
        for (int r = 0; r < 8; r++) begin
            bit done_with_byte;
            pulse_start();
            n = $urandom_range(0, 19);
            done_with_byte = 1'b0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) load_start = 1'b1;
                done_with_byte = (i == n - 1) && ($urandom_range(0, 1) == 1);
                send(8'($urandom), done_with_byte);
                load_start = 1'b0;
            end
            if (!done_with_byte) finish_load();
            for (int f = 0; f < 12; f++) begin
                rom_ce     = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0: rom_addr = 32'($urandom_range(0, 15));
                    1: rom_addr = 32'h10 | 32'($urandom_range(0, 15));
                    2: rom_addr = 32'h8000_0000 | 32'($urandom_range(0, 15));
                    default: rom_addr = $urandom;
                endcase
                load_done  = ($urandom_range(0, 5) == 0);
                load_valid = ($urandom_range(0, 3) == 0);
                load_byte  = 8'($urandom);
                tick();
            end
            rom_ce = 1'b0; load_done = 1'b0; load_valid = 1'b0;
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
